// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 scancode constants and types for the scancode-to-ASCII decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_ERR0     = 8'h00;
  localparam logic [7:0] SC_ERR1     = 8'hFF;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } xlat_t;

  // Keyboard-controller status bytes that carry no key information.
  function automatic logic is_ctrl_byte(logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Synchronous character FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module ps2_char_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode stream to ASCII: prefix tracking, Shift/Caps state, output FIFO.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          ENABLE_CAPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sc_data_i,
  input  logic       sc_valid_i,
  output logic [7:0] ascii_data_o,
  output logic       ascii_valid_o,
  input  logic       ascii_ready_i,
  output logic       shift_held_o,
  output logic       caps_lock_o,
  output logic       overflow_o,
  input  logic       overflow_clr_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  function automatic xlat_t translate(logic [7:0] code, logic shift, logic caps, logic ext);
    logic [7:0] letter, lo, hi;
    xlat_t      r;
    letter = '0;
    lo     = '0;
    hi     = '0;
    r      = '0;
    if (ext) begin
      if (code == SC_ENTER)         r = {1'b1, 8'h0D};
      else if (code == SC_KP_SLASH) r = {1'b1, 8'h2F};
    end else begin
      case (code)
        8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
        8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
        8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
        8'h45: {lo, hi} = {8'h30, 8'h29};  8'h16: {lo, hi} = {8'h31, 8'h21};
        8'h1E: {lo, hi} = {8'h32, 8'h40};  8'h26: {lo, hi} = {8'h33, 8'h23};
        8'h25: {lo, hi} = {8'h34, 8'h24};  8'h2E: {lo, hi} = {8'h35, 8'h25};
        8'h36: {lo, hi} = {8'h36, 8'h5E};  8'h3D: {lo, hi} = {8'h37, 8'h26};
        8'h3E: {lo, hi} = {8'h38, 8'h2A};  8'h46: {lo, hi} = {8'h39, 8'h28};
        8'h0E: {lo, hi} = {8'h60, 8'h7E};  8'h4E: {lo, hi} = {8'h2D, 8'h5F};
        8'h55: {lo, hi} = {8'h3D, 8'h2B};  8'h5D: {lo, hi} = {8'h5C, 8'h7C};
        8'h54: {lo, hi} = {8'h5B, 8'h7B};  8'h5B: {lo, hi} = {8'h5D, 8'h7D};
        8'h4C: {lo, hi} = {8'h3B, 8'h3A};  8'h52: {lo, hi} = {8'h27, 8'h22};
        8'h41: {lo, hi} = {8'h2C, 8'h3C};  8'h49: {lo, hi} = {8'h2E, 8'h3E};
        8'h4A: {lo, hi} = {8'h2F, 8'h3F};
        8'h29: {lo, hi} = {8'h20, 8'h20};  8'h5A: {lo, hi} = {8'h0D, 8'h0D};
        8'h66: {lo, hi} = {8'h08, 8'h08};  8'h0D: {lo, hi} = {8'h09, 8'h09};
        8'h76: {lo, hi} = {8'h1B, 8'h1B};
        default: ;
      endcase
      // Letters honour Shift xor Caps; everything else honours Shift only.
      if (letter != '0)  r = {1'b1, (shift ^ caps) ? (letter & 8'hDF) : letter};
      else if (lo != '0) r = {1'b1, shift ? hi : lo};
    end
    return r;
  endfunction

  prefix_state_t state_q, state_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d, caps_q, caps_d;
  logic          hit_q, hit_d, overflow_q, overflow_d;
  logic [7:0]    char_q, char_d;
  xlat_t         xlat;

  logic          fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;

  assign shift_held_o = lshift_q | rshift_q;
  assign caps_lock_o  = caps_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    caps_d   = caps_q;
    xlat     = '0;
    if (sc_valid_i) begin
      if (sc_data_i == SC_PAUSE) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (sc_data_i == SC_EXT) begin
              state_d = StExt;
            end else if (sc_data_i == SC_BRK) begin
              state_d = StBrk;
            end else if (is_ctrl_byte(sc_data_i)) begin
              if (sc_data_i == SC_BAT_OK) begin
                lshift_d = 1'b0;
                rshift_d = 1'b0;
              end
            end else begin
              if (sc_data_i == SC_LSHIFT) lshift_d = 1'b1;
              if (sc_data_i == SC_RSHIFT) rshift_d = 1'b1;
              if (ENABLE_CAPS && (sc_data_i == SC_CAPS)) caps_d = !caps_q;
              xlat = translate(sc_data_i, shift_held_o, caps_q, 1'b0);
            end
          end
          StExt: begin
            state_d = StIdle;
            if (sc_data_i == SC_BRK)      state_d = StExtBrk;
            else if (sc_data_i != SC_EXT) xlat = translate(sc_data_i, shift_held_o, caps_q, 1'b1);
          end
          StBrk: begin
            state_d = StIdle;
            if (sc_data_i == SC_LSHIFT) lshift_d = 1'b0;
            if (sc_data_i == SC_RSHIFT) rshift_d = 1'b0;
          end
          StExtBrk: state_d = StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end
    hit_d  = xlat.hit;
    char_d = xlat.ascii;
  end

  assign fifo_pop = ascii_valid_o && ascii_ready_i;
  assign drop     = hit_q && fifo_full && !fifo_pop;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr_i) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      hit_q      <= 1'b0;
      char_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      caps_q     <= caps_d;
      hit_q      <= hit_d;
      char_q     <= char_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hit_q),
    .data_i  (char_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ascii_valid_o = !fifo_empty;
  // Head storage is unreset, so hold the output at zero while nothing is queued.
  assign ascii_data_o  = (fifo_count != '0) ? fifo_data : 8'h00;

endmodule
